// File: rtl/alu_core_pkg.sv
// alu_core_pkg: opcode encoding shared by the ALU core and its divider.
package alu_core_pkg;
  localparam int OP_W = 3;
  typedef enum logic [OP_W-1:0] {
    OP_ADD, OP_AND, OP_SUB, OP_OR, OP_XOR, OP_MUL, OP_DIV, OP_SLT
  } op_e;
endpackage

// File: rtl/alu_core_div.sv
// alu_core_div: combinational unsigned divider; B=0 yields all-ones quotient and remainder A.
module alu_core_div #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);
  always_comb begin
    div_by_zero = b == '0;
    quotient    = div_by_zero ? '1 : a / b;
    remainder   = div_by_zero ? a : a % b;
  end
endmodule

// File: rtl/alu_core.sv
// alu_core: single-cycle registered ALU; divider compiled in only with ALU_CORE_DIV_EN.
module alu_core
  import alu_core_pkg::*;
#(
  parameter int N = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [N-1:0]    operand1,
  input  logic [N-1:0]    operand2,
  input  logic [OP_W-1:0] operation,
  output logic [2*N-1:0]  alu_out,
  output logic            out_valid,
  output logic            zero,
  output logic            div_by_zero
);
  logic [2*N-1:0] a, b, div_res, result;
  logic           div_zero;
  op_e            op;
  assign a  = {{N{1'b0}}, operand1};
  assign b  = {{N{1'b0}}, operand2};
  assign op = op_e'(operation);
`ifdef ALU_CORE_DIV_EN
  logic [N-1:0] quotient, remainder;
  alu_core_div #(.N(N)) u_div (
    .a           (operand1),
    .b           (operand2),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_zero)
  );
  assign div_res = {remainder, quotient};
`else
  assign div_res  = '0;
  assign div_zero = 1'b0;
`endif
  always_comb begin
    case (op)
      OP_ADD:  result = a + b;
      OP_AND:  result = a & b;
      OP_SUB:  result = a - b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_MUL:  result = a * b;
      OP_DIV:  result = div_res;
      default: result = {{(2*N-1){1'b0}}, $signed(operand1) < $signed(operand2)};
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_out     <= '0;
      out_valid   <= 1'b0;
      zero        <= 1'b1;
      div_by_zero <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        alu_out     <= result;
        zero        <= result == '0;
        div_by_zero <= (op == OP_DIV) && div_zero;
      end
    end
  end
endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed and random checks of alu_core (N=4) against an arithmetic reference model.
module tb_alu_core;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] operand1 = '0;
  logic [3:0] operand2 = '0;
  logic [2:0] operation = '0;
  logic [7:0] alu_out;
  logic       out_valid, zero, div_by_zero;
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_out = '0;
  logic exp_valid = 1'b0, exp_zero = 1'b1, exp_dbz = 1'b0;

  alu_core #(.N(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .operand1    (operand1),
    .operand2    (operand2),
    .operation   (operation),
    .alu_out     (alu_out),
    .out_valid   (out_valid),
    .zero        (zero),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic int ref_result(input int op, input int x, input int y);
    int sx, sy;
    sx = x > 7 ? x - 16 : x;
    sy = y > 7 ? y - 16 : y;
    case (op)
      0: return x + y;
      1: return x & y;
      2: return (x - y + 256) % 256;
      3: return x | y;
      4: return x ^ y;
      5: return x * y;
`ifdef ALU_CORE_DIV_EN
      6: return y == 0 ? x * 16 + 15 : (x % y) * 16 + x / y;
`else
      6: return 0;
`endif
      default: return sx < sy ? 1 : 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic r, input logic v, input int op, input int x, input int y);
    @(negedge clk);
    reset = r;
    in_valid = v;
    operation = 3'(op);
    operand1 = 4'(x);
    operand2 = 4'(y);
    @(posedge clk);
    #1;
    if (r) begin
      exp_out = '0; exp_valid = 1'b0; exp_zero = 1'b1; exp_dbz = 1'b0;
    end else begin
      exp_valid = v;
      if (v) begin
        exp_out  = 8'(ref_result(op, x, y));
        exp_zero = exp_out == 8'h00;
`ifdef ALU_CORE_DIV_EN
        exp_dbz = op == 6 && y == 0;
`else
        exp_dbz = 1'b0;
`endif
      end
    end
    chk("alu_out", alu_out, exp_out);
    chk("out_valid", 8'(out_valid), 8'(exp_valid));
    chk("zero", 8'(zero), 8'(exp_zero));
    chk("div_by_zero", 8'(div_by_zero), 8'(exp_dbz));
  endtask

  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 3, 3);
    chk("reset_out", alu_out, 8'h00);
    step(0, 1, 0, 2, 1);
    chk("add_2_1", alu_out, 8'h03);
    step(0, 1, 1, 9, 5);
    step(0, 1, 2, 12, 10);
    step(0, 1, 3, 7, 4);
    step(0, 1, 4, 12, 6);
    chk("xor_12_6", alu_out, 8'h0A);
    step(0, 1, 5, 4, 2);
    step(0, 1, 5, 15, 15);
    chk("mul_15_15", alu_out, 8'hE1);
    step(0, 1, 0, 15, 1);
    chk("add_carry", alu_out, 8'h10);
    step(0, 1, 2, 1, 2);
    chk("sub_wrap", alu_out, 8'hFF);
    step(0, 1, 6, 6, 3);
    step(0, 1, 6, 7, 2);
    step(0, 1, 6, 7, 0);
`ifdef ALU_CORE_DIV_EN
    chk("div_7_0", alu_out, 8'h7F);
`else
    chk("div_disabled", alu_out, 8'h00);
`endif
    step(0, 1, 7, 10, 3);
    chk("slt_neg", alu_out, 8'h01);
    step(0, 1, 7, 3, 10);
    step(0, 1, 7, 5, 5);
    step(0, 1, 0, 2, 1);
    step(0, 0, 5, 9, 9);
    chk("hold_after_drop", alu_out, 8'h03);
    step(0, 0, 1, 0, 0);
    step(1, 1, 5, 15, 15);
    step(0, 1, 0, 4, 4);
    for (int i = 0; i < 300; i++) begin
      int y;
      y = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 15);
      step($urandom_range(0, 19) == 0, $urandom_range(0, 4) != 0,
           $urandom_range(0, 7), $urandom_range(0, 15), y);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
